// File: rtl/button_conditioner.sv
// Per-channel 2-FF synchronizer, counter debouncer and press/release pulse generator for active-low buttons.
// Optional auto-repeat of Press_p while a button is held is built when BTN_REPEAT_EN is defined.
module button_conditioner #(
    parameter int NUM_BTN       = 4,
    parameter int DB_CYCLES     = 50000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] Btn_n,
    output logic [NUM_BTN-1:0] Level,
    output logic [NUM_BTN-1:0] Press_p,
    output logic [NUM_BTN-1:0] Release_p
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    if (NUM_BTN < 1 || DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_conditioner: NUM_BTN, DB_CYCLES and REPEAT_* must all be >= 1");
    end

    logic [NUM_BTN-1:0] s1_q, s1_d;
    logic [NUM_BTN-1:0] s2_q, s2_d;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] cand;
    logic [NUM_BTN-1:0] accept;
    logic [NUM_BTN-1:0] rep_fire;
    logic [CW-1:0]      cnt_q [NUM_BTN];
    logic [CW-1:0]      cnt_d [NUM_BTN];

    // Debounce: any cycle where the candidate agrees with the accepted level restarts the count.
    always_comb begin
        s1_d    = Btn_n;
        s2_d    = s1_q;
        cand    = ~s2_q;
        level_d = level_q;
        accept  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cand[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                level_d[i] = cand[i];
                cnt_d[i]   = '0;
                accept[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // rep_fire never coincides with accept, so press and release stay mutually exclusive.
    always_comb begin
        press_d   = (accept & cand) | rep_fire;
        release_d = accept & ~cand;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_q      <= '1;
            s2_q      <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX + 1) : 1;
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]      rcnt_q [NUM_BTN];
    logic [RW-1:0]      rcnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] rep_run_q, rep_run_d;

    // rep_run selects the first (delay) interval versus the later (period) intervals.
    always_comb begin
        rep_run_d = rep_run_q;
        rep_fire  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rcnt_d[i] = rcnt_q[i];
            if (!level_q[i] || accept[i]) begin
                rcnt_d[i]    = '0;
                rep_run_d[i] = 1'b0;
            end else if (rcnt_q[i] == (rep_run_q[i] ? RP_LAST : RD_LAST)) begin
                rcnt_d[i]    = '0;
                rep_run_d[i] = 1'b1;
                rep_fire[i]  = 1'b1;
            end else begin
                rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rep_run_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                rcnt_q[i] <= '0;
            end
        end else begin
            rep_run_q <= rep_run_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    assign Level     = level_q;
    assign Press_p   = press_q;
    assign Release_p = release_q;

endmodule
